// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits. Produces bit-boundary strobes for an external line driver.
module uart_tx_ctrl #(
  parameter int BIT_TICKS = 5208,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic [2:0] tx_state,
  output logic [7:0] tx_data,
  output logic [2:0] tx_data_index,
  output logic       tx_parity,
  output logic       end_bit_time,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    TX_DATA    = 3'd2,
    PARITY_BIT = 3'd3,
    STOP_BIT   = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic            stop_cnt;
  logic            par_en;
  logic            bit_end;

  assign bit_end  = (tick_cnt == CW'(BIT_TICKS - 1));
  assign tx_state = state;
  assign busy     = (state != IDLE);

  // Handshake: tx_start is a request honoured only while IDLE (busy low); while busy
  // it is ignored outright, and tx_done marks the single cycle the sequencer is free again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      stop_cnt      <= 1'b0;
      par_en        <= 1'b0;
      tx_data       <= 8'h00;
      tx_data_index <= 3'd0;
      tx_parity     <= 1'b0;
      end_bit_time  <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      tx_done      <= 1'b0;
      end_bit_time <= (state == IDLE) ? tx_start : bit_end;
      tick_cnt     <= (state == IDLE || bit_end) ? '0 : tick_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            state         <= START_BIT;
            tx_data       <= tx_data_in;
            par_en        <= parity_en;
            tx_parity     <= (^tx_data_in) ^ parity_odd;
            tx_data_index <= 3'd0;
            stop_cnt      <= 1'b0;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            state         <= TX_DATA;
            tx_data_index <= 3'd0;
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            if (tx_data_index == 3'd7) begin
              tx_data_index <= 3'd0;
              state         <= par_en ? PARITY_BIT : STOP_BIT;
            end else begin
              tx_data_index <= tx_data_index + 3'd1;
            end
          end
        end
        PARITY_BIT: begin
          if (bit_end) state <= STOP_BIT;
        end
        STOP_BIT: begin
          if (bit_end) begin
            // stop_cnt counts completed stop bits; last one returns to IDLE
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at BIT_TICKS=4: one instance with one stop bit,
// one with two stop bits; expected slot sequences and frame lengths are hand-derived.
module tb_uart_tx_ctrl;

  localparam int BT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;

  logic       start1, start2;
  logic [2:0] st1, st2, ix1, ix2;
  logic [7:0] d1, d2;
  logic       p1, p2, e1, e2, b1, b2, dn1, dn2;

  logic [2:0] o_state, o_idx;
  logic [7:0] o_data;
  logic       o_par, o_ebt, o_busy, o_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign start1  = start & ~sel;
  assign start2  = start & sel;
  assign o_state = sel ? st2 : st1;
  assign o_idx   = sel ? ix2 : ix1;
  assign o_data  = sel ? d2  : d1;
  assign o_par   = sel ? p2  : p1;
  assign o_ebt   = sel ? e2  : e1;
  assign o_busy  = sel ? b2  : b1;
  assign o_done  = sel ? dn2 : dn1;

  uart_tx_ctrl #(.BIT_TICKS(BT), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .tx_start(start1), .tx_data_in(tx_data_in),
    .parity_en(parity_en), .parity_odd(parity_odd), .tx_state(st1), .tx_data(d1),
    .tx_data_index(ix1), .tx_parity(p1), .end_bit_time(e1), .busy(b1), .tx_done(dn1)
  );

  uart_tx_ctrl #(.BIT_TICKS(BT), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_start(start2), .tx_data_in(tx_data_in),
    .parity_en(parity_en), .parity_odd(parity_odd), .tx_state(st2), .tx_data(d2),
    .tx_data_index(ix2), .tx_parity(p2), .end_bit_time(e2), .busy(b2), .tx_done(dn2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {5'd0, o_state}, 8'd0);
    chk({tag, "_index"}, {5'd0, o_idx}, 8'd0);
    chk({tag, "_data"}, o_data, 8'd0);
    chk({tag, "_parity"}, {7'd0, o_par}, 8'd0);
    chk({tag, "_ebt"}, {7'd0, o_ebt}, 8'd0);
    chk({tag, "_busy"}, {7'd0, o_busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, o_done}, 8'd0);
  endtask

  // Runs one frame from the accept edge to the tx_done cycle, checking every cycle.
  task automatic frame(input logic s, input logic [7:0] d, input logic pen, input logic podd,
                       input int stops, input logic exp_par, input int exp_len,
                       input logic hold, input logic inject);
    logic [2:0] st_q[$];
    logic [2:0] ix_q[$];
    int len;
    sel = s;
    tx_data_in = d;
    parity_en = pen;
    parity_odd = podd;
    start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    st_q.push_back(3'd1); ix_q.push_back(3'd0);
    for (int k = 0; k < 8; k++) begin
      st_q.push_back(3'd2); ix_q.push_back(3'(k));
    end
    if (pen) begin
      st_q.push_back(3'd3); ix_q.push_back(3'd0);
    end
    for (int k = 0; k < stops; k++) begin
      st_q.push_back(3'd4); ix_q.push_back(3'd0);
    end
    len = 0;
    for (int i = 0; i < st_q.size(); i++) begin
      for (int c = 0; c < BT; c++) begin
        chk("state", {5'd0, o_state}, {5'd0, st_q[i]});
        chk("index", {5'd0, o_idx}, {5'd0, ix_q[i]});
        chk("end_bit_time", {7'd0, o_ebt}, {7'd0, c == 0});
        chk("busy", {7'd0, o_busy}, 8'd1);
        chk("tx_done_early", {7'd0, o_done}, 8'd0);
        chk("tx_data", o_data, d);
        chk("tx_parity", {7'd0, o_par}, {7'd0, exp_par});
        if (inject && i == 3 && c == 1) begin
          start = 1'b1;
          tx_data_in = 8'hFF;
        end else if (inject) begin
          start = 1'b0;
          tx_data_in = d;
        end
        tick;
        len++;
      end
    end
    chk("frame_len", 8'(len), 8'(exp_len));
    chk("end_state", {5'd0, o_state}, 8'd0);
    chk("end_ebt", {7'd0, o_ebt}, 8'd1);
    chk("end_done", {7'd0, o_done}, 8'd1);
    chk("end_busy", {7'd0, o_busy}, 8'd0);
    chk("end_data", o_data, d);
  endtask

  task automatic idle_check(input string tag);
    tick;
    chk({tag, "_state"}, {5'd0, o_state}, 8'd0);
    chk({tag, "_ebt"}, {7'd0, o_ebt}, 8'd0);
    chk({tag, "_done"}, {7'd0, o_done}, 8'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    sel = 1'b0;
    chk_reset_vals("rst1");
    sel = 1'b1;
    chk_reset_vals("rst2");
    sel = 1'b0;
    rst = 1'b0;
    tick;

    // 0x55, no parity: 10 slots of 4 cycles
    frame(1'b0, 8'h55, 1'b0, 1'b0, 1, 1'b0, 40, 1'b0, 1'b0);
    idle_check("idle_after_55");

    // 0xA3 has four ones: even parity 0, odd parity 1
    frame(1'b0, 8'hA3, 1'b1, 1'b0, 1, 1'b0, 44, 1'b0, 1'b0);
    frame(1'b0, 8'hA3, 1'b1, 1'b1, 1, 1'b1, 44, 1'b0, 1'b0);
    idle_check("idle_after_a3");

    // tx_start with 0xFF during TX_DATA of a 0x12 frame is ignored
    frame(1'b0, 8'h12, 1'b0, 1'b0, 1, 1'b0, 40, 1'b0, 1'b1);
    idle_check("idle_after_12");

    // two stop bits on the second instance
    frame(1'b1, 8'h00, 1'b0, 1'b0, 2, 1'b0, 44, 1'b0, 1'b0);
    idle_check("idle_after_stop2");

    // asynchronous reset in TX_DATA index 3
    sel = 1'b0;
    tx_data_in = 8'h12;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (16) tick;
    chk("pre_rst_state", {5'd0, o_state}, 8'd2);
    chk("pre_rst_index", {5'd0, o_idx}, 8'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick;
    chk_reset_vals("held_rst");
    rst = 1'b0;
    frame(1'b0, 8'h12, 1'b0, 1'b0, 1, 1'b0, 40, 1'b0, 1'b0);

    // tx_start held high: second accept lands on the tx_done cycle
    frame(1'b0, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 40, 1'b1, 1'b0);
    frame(1'b0, 8'hC3, 1'b1, 1'b1, 1, 1'b1, 44, 1'b0, 1'b0);
    idle_check("idle_after_b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 5208, meaning clk cycles per serial bit (legal range >= 2).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning number of stop bits per frame (legal values 1, 2).
REQ-003 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port tx_start  input  1  frame request, sampled only in IDLE.
REQ-006 SHALL have port tx_data_in  input  8  byte to send, latched on accept.
REQ-007 SHALL have port parity_en  input  1  parity bit inserted when 1, latched on accept.
REQ-008 SHALL have port parity_odd  input  1  odd parity when 1, even when 0, latched on accept.
REQ-009 SHALL have port tx_state  output  3  encoding: IDLE=0, START_BIT=1, TX_DATA=2, PARITY_BIT=3, STOP_BIT=4.
REQ-010 SHALL have port tx_data  output  8  latched byte.
REQ-011 SHALL have port tx_data_index  output  3  data bit number, LSB first.
REQ-012 SHALL have port tx_parity  output  1  computed parity bit.
REQ-013 SHALL have port end_bit_time  output  1  one-cycle bit-boundary strobe to the line driver.
REQ-014 SHALL have port busy  output  1  high while tx_state != IDLE.
REQ-015 SHALL have port tx_done  output  1  one-cycle frame-complete pulse.

Function
REQ-016 SHALL accept a frame on a rising edge where tx_state==IDLE and tx_start==1: latch tx_data_in, parity_en and parity_odd; set tx_state=START_BIT; clear the bit counter.
REQ-017 SHALL ignore tx_start whenever tx_state!=IDLE; no queuing, and latched values stay unchanged.
REQ-018 SHALL compute tx_parity at accept as XOR of tx_data_in XOR parity_odd, and hold it until the next accept.
REQ-019 SHALL run a bit counter 0..BIT_TICKS-1 in every non-IDLE state; on the edge at count BIT_TICKS-1 it wraps to 0 and an advance occurs.
REQ-020 SHALL advance states as: START_BIT->TX_DATA with index 0; TX_DATA index<7 -> TX_DATA with index+1; TX_DATA index 7 -> PARITY_BIT if latched parity_en, else STOP_BIT; PARITY_BIT->STOP_BIT; STOP_BIT -> IDLE after STOP_BITS advances in STOP_BIT.
REQ-021 SHALL drive tx_data_index to 0 in every state other than TX_DATA.
REQ-022 SHALL register end_bit_time so that it is high for exactly the one cycle after each tx_state/tx_data_index update (accept, every advance, return to IDLE), with the new values stable during that cycle.
REQ-023 SHALL hold every bit state for exactly BIT_TICKS cycles; the frame spans (1+8+P+STOP_BITS)*BIT_TICKS cycles from the accept edge to the return-to-IDLE edge, where P is the latched parity_en.
REQ-024 SHALL pulse tx_done for one cycle, coincident with the end_bit_time of the STOP_BIT->IDLE transition.
REQ-025 SHALL accept tx_start on the tx_done cycle (tx_state is IDLE then), so back-to-back frames have exactly one cycle of IDLE state.
REQ-026 SHALL size the bit counter as $clog2(BIT_TICKS) bits, with no overflow past BIT_TICKS-1.

Reset
REQ-027 SHALL, while rst==1 and independent of clk, force tx_state=IDLE, tx_data_index=0, tx_data=0, tx_parity=0, end_bit_time=0, busy=0, tx_done=0, and all counters to 0.
REQ-028 SHALL abort a frame on reset mid-operation with no tx_done pulse, and accept a new tx_start on the first rising edge after release.

Verification (BIT_TICKS=4 unless noted)
REQ-029 SHALL cover: tx_start with 0x55 and parity_en=0 -> tx_state 1, 2 (index 0..7), 4, 0; end_bit_time every 4 cycles; 40 cycles; one tx_done.
REQ-030 SHALL cover: 0xA3 with parity_en=1 -> tx_parity=0 when parity_odd=0 and 1 when parity_odd=1; PARITY_BIT held 4 cycles; 44-cycle frame.
REQ-031 SHALL cover: tx_start=1 with 0xFF during TX_DATA of a 0x12 frame -> ignored, tx_data stays 0x12, frame length unchanged.
REQ-032 SHALL cover: STOP_BITS=2, 0x00, no parity -> STOP_BIT held 8 cycles, 44-cycle frame, single tx_done.
REQ-033 SHALL cover: rst pulse asynchronously in TX_DATA index 3 -> all outputs reset immediately, no tx_done, next tx_start accepted normally.
REQ-034 SHALL cover: tx_start held high across two frames -> second accept on the tx_done cycle; IDLE visible for 1 cycle; both frames complete.
